bomb_game_seq: RTL and testbench
================================

Name: bomb_game_seq

Overview:
Parametrised top-level sequencer for the bomb-defusal game. It replaces the single-round control block with a multi-level game state machine that includes:
- an internal LFSR code generator,
- a seconds prescaler, with show and countdown timers held internally,
- a strike counter for wrong guesses,
- win/lose hold with optional auto-restart.

It sits between the board switches and buttons and the display, verifier and countdown submodules, and drives their enables and a shared reset pulse.

Parameters:
CODE_W, 5, width of generated code (1..16)
LEVELS, 3, rounds per game (>=2); level index width LVL_W=$clog2(LEVELS)
TICK_DIV, 50_000_000, clk cycles per one-second tick (>=2)
SHOW_SECS, 5, code display time per round
BASE_SECS, 20, level-0 countdown (<=255)
STEP_SECS, 4, countdown reduction per level
MIN_SECS, 8, countdown floor
MAX_MISS, 3, wrong guesses allowed per round before loss (>=1)
HOLD_SECS, 3, win/lose display time before auto-restart

Ports:
clk  in  1  system clock
Rst  in  1  reset, synchronous, active-low
en  in  1  master switch; low forces OFF
btn  in  1  start button, already synchronised; rising edge used
auto_restart  in  1  restart automatically after HOLD_SECS in WIN/LOSE
guess_ok  in  1  one-cycle pulse from verifier: correct code
guess_bad  in  1  one-cycle pulse from verifier: wrong code
code  out  CODE_W  current round code
level  out  LVL_W  current round index
time_left  out  8  remaining countdown seconds
misses  out  2+  wrong guesses this round, width $clog2(MAX_MISS+1)
bomb_en, show_en, input_en, timer_en  out  1  submodule enables
win, lose  out  1  result flags
sub_rst_n  out  1  active-low reset pulse to submodules

Behaviour:
- Reset (Rst=0):
  - State is OFF.
  - All outputs are 0 except sub_rst_n=0.
  - LFSR is set to 16'hACE1.
  - Prescaler is cleared.
  - btn edge register is cleared.
- sub_rst_n is 1 from the first cycle after reset release, except for the pulses defined below.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Advances every cycle while en=1, in every state.
  - Gives CODE_W bits, lfsr[CODE_W-1:0], at SEED; an all-zero code is legal.
- Tick:
  - Prescaler counts 0..TICK_DIV-1; tick=1 in the cycle count==TICK_DIV-1.
  - Prescaler clears on every state change, so the first tick arrives TICK_DIV cycles after state entry.
- en=0 in any state: next state is OFF. This has priority over all other transitions.
  - Entering OFF from a non-OFF state drives sub_rst_n=0 for exactly one cycle.
  - In OFF, all enables and win/lose are 0, and level, misses and time_left are 0.
- States:
  - OFF: en=1 -> IDLE.
  - IDLE: bomb_en=1. btn rising edge -> SEED with level=0.
  - SEED (1 cycle):
    - Latch code, clear misses, sub_rst_n=0 this cycle.
    - Load time_left = max(BASE_SECS - level*STEP_SECS, MIN_SECS). Compute this in 16 bits with saturating subtract.
    - -> SHOW.
  - SHOW: bomb_en=1, show_en=1. After SHOW_SECS ticks -> PLAY.
  - PLAY: bomb_en=1, input_en=1, timer_en=1. Priority per cycle:
    1. guess_ok: if level==LEVELS-1 -> WIN; else level+1 -> SEED.
    2. guess_bad: misses+1; if new misses==MAX_MISS -> LOSE.
    3. tick: time_left-1; if the result is 0 -> LOSE.
  - Simultaneous events in PLAY:
    - guess_ok with tick or guess_bad: ok wins and time_left is not decremented.
    - guess_bad with tick: both take effect, and LOSE follows if either condition is met.
  - WIN / LOSE:
    - win=1 or lose=1 respectively. All other enables are 0. code, level, time_left and misses hold.
    - After HOLD_SECS ticks, if auto_restart=1 -> SEED with level=0.
    - A btn rising edge at any time in WIN/LOSE -> SEED with level=0.
    - Otherwise remain.
- btn edges outside IDLE, WIN and LOSE are ignored.
- guess pulses outside PLAY are ignored.
- All outputs are registered; enables update the cycle after the state transition.

Test Plan:
(TICK_DIV=4, SHOW_SECS=2, BASE_SECS=5, STEP_SECS=1, MIN_SECS=4, LEVELS=3, MAX_MISS=2, HOLD_SECS=2)
1. Rst low 3 cycles, then en=1 -> outputs 0 and sub_rst_n=0 during reset; one cycle after release, state IDLE, bomb_en=1, sub_rst_n=1.
2. btn edge -> single-cycle sub_rst_n=0, code=lfsr[4:0], show_en=1 for 8 cycles; then input_en=timer_en=1 and time_left=5, counting 5,4,...,0 every 4 cycles -> lose=1 when 0 is reached.
3. guess_ok at levels 0,1,2 -> time_left loads 5, 4, 4 (floor at MIN_SECS); third ok -> win=1, level=2.
4. Two guess_bad pulses in one round -> misses=1 then lose=1. guess_bad together with the tick at time_left=1 -> lose.
5. guess_ok in the same cycle as the tick at time_left=1 -> no lose, level increments, next round SEED.
6. From LOSE with auto_restart=1 -> SEED after 8 cycles with level=0, misses=0. Dropping en mid-PLAY -> OFF next cycle, one-cycle sub_rst_n pulse, all enables 0.

Source files
------------

// File: rtl/bomb_game_seq.sv
// Multi-level game sequencer for the bomb-defusal board: LFSR code source, seconds
// prescaler, show/countdown/hold timing, strike counting and submodule enable control.
module bomb_game_seq #(
  parameter int CODE_W    = 5,
  parameter int LEVELS    = 3,
  parameter int TICK_DIV  = 50_000_000,
  parameter int SHOW_SECS = 5,
  parameter int BASE_SECS = 20,
  parameter int STEP_SECS = 4,
  parameter int MIN_SECS  = 8,
  parameter int MAX_MISS  = 3,
  parameter int HOLD_SECS = 3,
  localparam int LVL_W    = $clog2(LEVELS),
  localparam int MISS_W   = $clog2(MAX_MISS + 1)
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              en,
  input  logic              btn,
  input  logic              auto_restart,
  input  logic              guess_ok,
  input  logic              guess_bad,
  output logic [CODE_W-1:0] code,
  output logic [LVL_W-1:0]  level,
  output logic [7:0]        time_left,
  output logic [MISS_W-1:0] misses,
  output logic              bomb_en,
  output logic              show_en,
  output logic              input_en,
  output logic              timer_en,
  output logic              win,
  output logic              lose,
  output logic              sub_rst_n
);

  localparam int DIV_W   = $clog2(TICK_DIV);
  localparam int SEC_MAX = (SHOW_SECS > HOLD_SECS) ? SHOW_SECS : HOLD_SECS;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);
  localparam int SUM_W   = SEC_W + 1;

  typedef enum logic [2:0] {
    S_OFF, S_IDLE, S_SEED, S_SHOW, S_PLAY, S_WIN, S_LOSE
  } state_t;

  state_t state, nxt;

  logic [15:0]       lfsr;
  logic              btn_q, rise, tick;
  logic [DIV_W-1:0]  div_cnt;
  logic [SEC_W-1:0]  sec_cnt;
  logic [SUM_W-1:0]  sec_sum;
  logic              show_done, hold_done;
  logic [MISS_W-1:0] miss_inc;
  logic              miss_lose, time_lose, last_lvl;
  logic              bomb_d, show_d, input_d, timer_d, win_d, lose_d, sub_rst_d;

  // Countdown for a level: BASE - level*STEP, floored at MIN, saturating at zero.
  function automatic logic [7:0] round_secs(input logic [LVL_W-1:0] lvl);
    logic [15:0] dec, rem;
    dec = 16'(lvl) * 16'(STEP_SECS);
    rem = (16'(BASE_SECS) > dec) ? 16'(BASE_SECS) - dec : 16'd0;
    if (rem < 16'(MIN_SECS)) rem = 16'(MIN_SECS);
    return rem[7:0];
  endfunction

  assign rise      = btn & ~btn_q;
  assign tick      = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign sec_sum   = {1'b0, sec_cnt} + {{SEC_W{1'b0}}, tick};
  assign show_done = tick && (sec_sum == SUM_W'(SHOW_SECS));
  // Hold completion stays true once reached so a late auto_restart still restarts.
  assign hold_done = auto_restart && (sec_sum >= SUM_W'(HOLD_SECS));
  assign miss_inc  = misses + MISS_W'(1);
  assign miss_lose = guess_bad && (miss_inc == MISS_W'(MAX_MISS));
  assign time_lose = tick && (time_left == 8'd1);
  assign last_lvl  = (level == LVL_W'(LEVELS - 1));

  always_ff @(posedge clk) begin
    if (!Rst) state <= S_OFF;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!en) begin
      nxt = S_OFF;
    end else begin
      case (state)
        S_OFF:  nxt = S_IDLE;
        S_IDLE: if (rise) nxt = S_SEED;
        S_SEED: nxt = S_SHOW;
        S_SHOW: if (show_done) nxt = S_PLAY;
        S_PLAY: begin
          if (guess_ok)                   nxt = last_lvl ? S_WIN : S_SEED;
          else if (miss_lose || time_lose) nxt = S_LOSE;
        end
        S_WIN, S_LOSE: if (rise || hold_done) nxt = S_SEED;
        default: nxt = S_OFF;
      endcase
    end
  end

  always_comb begin
    bomb_d  = 1'b0;
    show_d  = 1'b0;
    input_d = 1'b0;
    timer_d = 1'b0;
    win_d   = 1'b0;
    lose_d  = 1'b0;
    case (nxt)
      S_IDLE, S_SEED: bomb_d = 1'b1;
      S_SHOW: begin bomb_d = 1'b1; show_d = 1'b1; end
      S_PLAY: begin bomb_d = 1'b1; input_d = 1'b1; timer_d = 1'b1; end
      S_WIN:  win_d = 1'b1;
      S_LOSE: lose_d = 1'b1;
      default: ;
    endcase
    sub_rst_d = !((nxt == S_SEED) || ((nxt == S_OFF) && (state != S_OFF)));
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      lfsr      <= 16'hACE1;
      btn_q     <= 1'b0;
      div_cnt   <= '0;
      sec_cnt   <= '0;
      code      <= '0;
      level     <= '0;
      time_left <= '0;
      misses    <= '0;
      bomb_en   <= 1'b0;
      show_en   <= 1'b0;
      input_en  <= 1'b0;
      timer_en  <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
      sub_rst_n <= 1'b0;
    end else begin
      btn_q <= btn;
      if (en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      if (nxt != state || tick) div_cnt <= '0;
      else                      div_cnt <= div_cnt + DIV_W'(1);
      if (nxt != state)                    sec_cnt <= '0;
      else if (sec_cnt != SEC_W'(SEC_MAX)) sec_cnt <= sec_sum[SEC_W-1:0];

      bomb_en   <= bomb_d;
      show_en   <= show_d;
      input_en  <= input_d;
      timer_en  <= timer_d;
      win       <= win_d;
      lose      <= lose_d;
      sub_rst_n <= sub_rst_d;

      // Round data: cleared in OFF, loaded leaving SEED, updated by PLAY events.
      if (nxt == S_OFF) begin
        code      <= '0;
        level     <= '0;
        time_left <= '0;
        misses    <= '0;
      end else begin
        if (nxt == S_SEED) level <= (state == S_PLAY) ? level + LVL_W'(1) : '0;
        if (state == S_SEED) begin
          code      <= lfsr[CODE_W-1:0];
          misses    <= '0;
          time_left <= round_secs(level);
        end else if (state == S_PLAY && !guess_ok) begin
          if (guess_bad) misses <= miss_inc;
          if (tick)      time_left <= time_left - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bomb_game_seq.sv
// Bench for bomb_game_seq: directed game scenarios followed by randomized play,
// every cycle compared against a phase/cycle-count model of the game rules.
module tb_bomb_game_seq;

  localparam int CODE_W = 5, LEVELS = 3, TD = 4, SHOW = 2, BASE = 5;
  localparam int STEP = 1, MINS = 4, MAXM = 2, HOLD = 2;
  localparam int P_OFF = 0, P_IDLE = 1, P_SEED = 2, P_SHOW = 3, P_PLAY = 4, P_WIN = 5, P_LOSE = 6;

  logic clk = 1'b0;
  logic Rst, en, btn, auto_restart, guess_ok, guess_bad;
  logic [CODE_W-1:0] code;
  logic [1:0] level;
  logic [7:0] time_left;
  logic [1:0] misses;
  logic bomb_en, show_en, input_en, timer_en, win, lose, sub_rst_n;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int ph, k, m_level, m_miss, m_time, m_code;
  bit m_sub, btn_prev;
  bit [15:0] m_lfsr;

  bomb_game_seq #(
    .CODE_W(CODE_W), .LEVELS(LEVELS), .TICK_DIV(TD), .SHOW_SECS(SHOW),
    .BASE_SECS(BASE), .STEP_SECS(STEP), .MIN_SECS(MINS), .MAX_MISS(MAXM),
    .HOLD_SECS(HOLD)
  ) dut (
    .clk(clk), .Rst(Rst), .en(en), .btn(btn), .auto_restart(auto_restart),
    .guess_ok(guess_ok), .guess_bad(guess_bad), .code(code), .level(level),
    .time_left(time_left), .misses(misses), .bomb_en(bomb_en), .show_en(show_en),
    .input_en(input_en), .timer_en(timer_en), .win(win), .lose(lose),
    .sub_rst_n(sub_rst_n)
  );

  always #5 clk = ~clk;

  function automatic int secs_for(input int l);
    int t;
    t = BASE - l * STEP;
    return (t < MINS) ? MINS : t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    int nph;
    bit rise, tick;
    if (!Rst) begin
      ph = P_OFF; k = 0; m_level = 0; m_miss = 0; m_time = 0; m_code = 0;
      m_sub = 1'b0; m_lfsr = 16'hACE1; btn_prev = 1'b0;
      return;
    end
    rise = btn && !btn_prev;
    tick = ((k + 1) % TD) == 0;
    nph = ph;
    if (!en) nph = P_OFF;
    else begin
      case (ph)
        P_OFF:  nph = P_IDLE;
        P_IDLE: if (rise) begin nph = P_SEED; m_level = 0; end
        P_SEED: begin
          nph = P_SHOW; m_code = int'(m_lfsr[CODE_W-1:0]); m_miss = 0; m_time = secs_for(m_level);
        end
        P_SHOW: if (k + 1 == SHOW * TD) nph = P_PLAY;
        P_PLAY: begin
          if (guess_ok) begin
            if (m_level == LEVELS - 1) nph = P_WIN;
            else begin m_level++; nph = P_SEED; end
          end else begin
            if (guess_bad) m_miss++;
            if (tick) m_time--;
            if (m_miss == MAXM || (tick && m_time == 0)) nph = P_LOSE;
          end
        end
        default: if (rise || (auto_restart && k + 1 >= HOLD * TD)) begin nph = P_SEED; m_level = 0; end
      endcase
    end
    m_sub = !(nph == P_SEED || (nph == P_OFF && ph != P_OFF));
    if (nph == P_OFF) begin m_level = 0; m_miss = 0; m_time = 0; m_code = 0; end
    k = (nph == ph) ? k + 1 : 0;
    ph = nph;
    if (en) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    btn_prev = btn;
  endtask

  task automatic check_all();
    bit run;
    run = (ph == P_IDLE || ph == P_SEED || ph == P_SHOW || ph == P_PLAY);
    chk("code", code, m_code);
    chk("level", level, m_level);
    chk("time_left", time_left, m_time);
    chk("misses", misses, m_miss);
    chk("bomb_en", bomb_en, run);
    chk("show_en", show_en, ph == P_SHOW);
    chk("input_en", input_en, ph == P_PLAY);
    chk("timer_en", timer_en, ph == P_PLAY);
    chk("win", win, ph == P_WIN);
    chk("lose", lose, ph == P_LOSE);
    chk("sub_rst_n", sub_rst_n, m_sub);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_ok();
    guess_ok = 1'b1; step(); guess_ok = 1'b0;
  endtask

  task automatic pulse_bad();
    guess_bad = 1'b1; step(); guess_bad = 1'b0;
  endtask

  // btn rise -> SEED, SHOW entry, then the full show period into PLAY.
  task automatic start_round();
    btn = 1'b1; step(); btn = 1'b0;
    step();
    run(SHOW * TD);
  endtask

  initial begin
    Rst = 1'b0; en = 1'b0; btn = 1'b0; auto_restart = 1'b0; guess_ok = 1'b0; guess_bad = 1'b0;
    #2;
    run(3);
    chk("rst_bomb", bomb_en, 1'b0);
    chk("rst_sub", sub_rst_n, 1'b0);
    Rst = 1'b1; en = 1'b1;
    step();
    chk("idle_bomb", bomb_en, 1'b1);
    chk("idle_sub", sub_rst_n, 1'b1);

    // First round: let the countdown expire.
    btn = 1'b1; step(); btn = 1'b0;
    chk("seed_sub", sub_rst_n, 1'b0);
    step();
    chk("show_en", show_en, 1'b1);
    chk("show_time", time_left, 8'd5);
    run(7);
    chk("show_last", show_en, 1'b1);
    step();
    chk("play_input", input_en, 1'b1);
    chk("play_time", time_left, 8'd5);
    run(19);
    chk("cd_time1", time_left, 8'd1);
    step();
    chk("cd_lose", lose, 1'b1);
    chk("cd_time0", time_left, 8'd0);

    // Three correct guesses: countdown loads 5, 4, 4, then WIN.
    start_round();
    pulse_ok();
    chk("lvl1", level, 2'd1);
    step();
    chk("lvl1_time", time_left, 8'd4);
    run(SHOW * TD);
    pulse_ok();
    chk("lvl2", level, 2'd2);
    step();
    chk("lvl2_time", time_left, 8'd4);
    run(SHOW * TD);
    pulse_ok();
    chk("win", win, 1'b1);
    chk("win_level", level, 2'd2);

    // Two wrong guesses lose the round.
    start_round();
    pulse_bad();
    chk("miss1", misses, 2'd1);
    chk("miss1_lose", lose, 1'b0);
    step();
    pulse_bad();
    chk("miss2_lose", lose, 1'b1);

    // Wrong guess coinciding with the final tick.
    start_round();
    run(19);
    pulse_bad();
    chk("badtick_lose", lose, 1'b1);
    chk("badtick_time", time_left, 8'd0);

    // Correct guess coinciding with the final tick.
    start_round();
    run(19);
    pulse_ok();
    chk("oktick_lose", lose, 1'b0);
    chk("oktick_level", level, 2'd1);
    chk("oktick_time", time_left, 8'd1);
    step();
    chk("oktick_next", time_left, 8'd4);

    // Auto restart from LOSE after the hold period.
    run(SHOW * TD);
    pulse_bad(); step(); pulse_bad();
    auto_restart = 1'b1;
    run(HOLD * TD - 1);
    chk("hold_lose", lose, 1'b1);
    step();
    chk("auto_level", level, 2'd0);
    chk("auto_sub", sub_rst_n, 1'b0);
    auto_restart = 1'b0;
    step();
    chk("auto_misses", misses, 2'd0);

    // Master switch dropped mid-PLAY.
    run(SHOW * TD);
    run(5);
    en = 1'b0;
    step();
    chk("off_sub", sub_rst_n, 1'b0);
    chk("off_input", input_en, 1'b0);
    chk("off_bomb", bomb_en, 1'b0);
    step();
    chk("off_sub_hi", sub_rst_n, 1'b1);
    en = 1'b1;
    step();
    chk("back_idle", bomb_en, 1'b1);

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 99) != 0);
      Rst = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      if ($urandom_range(0, 49) == 0) auto_restart = ~auto_restart;
      guess_ok = ($urandom_range(0, 19) == 0);
      guess_bad = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
